flux_write_encoder: RTL and testbench

- Transmit-side counterpart of the disk controller's flux capture path.
- Consumes a stream of flux-interval words (clk cycles between transitions), buffers them in an internal FIFO, and regenerates timed write pulses (wr_data) under a write-gate envelope (wr_gate) for the drive's write circuitry.
- Sits in the clk_sys domain beside the disk controller. It is fed by firmware or DMA through a valid/ready stream.

---
 rtl/flux_write_encoder.sv | 185 ++++++++++++++++++
 tb/tb_flux_write_encoder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flux_write_encoder.sv
// flux_write_encoder
// Transmit-side flux regenerator: buffers flux-interval words (clk cycles
// between transitions) in a FIFO and replays them as timed wr_data pulses
// under a wr_gate envelope.
// Optional build macro FLUX_WRITE_INDEX_SYNC_EN: when defined, the first
// interval is popped only on a rising edge of index_in seen while the FIFO
// holds data; otherwise index_in is ignored.
module flux_write_encoder #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned PULSE_WIDTH  = 10,
    parameter int unsigned MIN_INTERVAL = 20
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CNT_WIDTH-1:0]            s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            index_in,
    output logic                            wr_gate,
    output logic                            wr_data,
    output logic                            busy,
    output logic                            done,
    output logic                            underrun,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [31:0]                     pulse_count
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LW   = AW + 1;
    localparam int unsigned PW_W = $clog2(PULSE_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WRITE,
        TAIL
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CNT_WIDTH-1:0]   head;
    logic [CNT_WIDTH-1:0]   interval_eff;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [PW_W-1:0]        pw_cnt;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   arm_go;
    logic                   fire;

    assign fifo_empty = (fifo_level == '0);
    assign s_ready    = (fifo_level != LW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready && !abort;
    assign head       = mem[rd_ptr];
    assign busy       = (state != IDLE);

    // Nonzero intervals shorter than the minimum are stretched to it
    assign interval_eff = (head < CNT_WIDTH'(MIN_INTERVAL)) ? CNT_WIDTH'(MIN_INTERVAL) : head;

`ifdef FLUX_WRITE_INDEX_SYNC_EN
    logic index_prev;
    logic index_rise;

    assign index_rise = index_in && !index_prev;

    // Previous index level for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) index_prev <= 1'b0;
        else     index_prev <= index_in;
    end

    assign arm_go = (state == ARM) && !fifo_empty && index_rise;
`else
    logic unused_index;
    assign unused_index = index_in;
    assign arm_go = (state == ARM) && !fifo_empty;
`endif

    // Counter expiry in WRITE is the pop point for the next interval
    assign fire = (state == WRITE) && (cnt == '0);
    assign pop  = !abort && (arm_go || (fire && !fifo_empty));

    // FIFO storage; no reset needed, validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // FIFO pointers and occupancy; abort flushes and drops any same-cycle push
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sequencer: arm, interval countdown, pulse generation and tail-off
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_gate     <= 1'b0;
            wr_data     <= 1'b0;
            done        <= 1'b0;
            underrun    <= 1'b0;
            pulse_count <= '0;
            cnt         <= '0;
            pw_cnt      <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                wr_gate <= 1'b0;
                wr_data <= 1'b0;
            end else begin
                // Pulse width timer; never overlaps a new pulse since
                // every interval exceeds the pulse width
                if (wr_data) begin
                    if (pw_cnt == '0) wr_data <= 1'b0;
                    else              pw_cnt  <= pw_cnt - PW_W'(1);
                end
                case (state)
                    IDLE: begin
                        if (start) begin
                            underrun    <= 1'b0;
                            pulse_count <= '0;
                            state       <= ARM;
                        end
                    end
                    ARM: begin
                        if (arm_go) begin
                            if (head == '0) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                // Load N-1 so the pulse lands N cycles after the gate
                                cnt     <= interval_eff - CNT_WIDTH'(1);
                                wr_gate <= 1'b1;
                                state   <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (fire) begin
                            wr_data <= 1'b1;
                            pw_cnt  <= PW_W'(PULSE_WIDTH - 1);
                            if (pulse_count != '1) pulse_count <= pulse_count + 32'd1;
                            if (fifo_empty) begin
                                underrun <= 1'b1;
                                state    <= TAIL;
                            end else if (head == '0) begin
                                state <= TAIL;
                            end else begin
                                cnt <= interval_eff - CNT_WIDTH'(1);
                            end
                        end else begin
                            cnt <= cnt - CNT_WIDTH'(1);
                        end
                    end
                    TAIL: begin
                        if (!wr_data) begin
                            wr_gate <= 1'b0;
                            done    <= !underrun;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flux_write_encoder.sv
// tb_flux_write_encoder
// Directed bench with a timeline model: from the word list and the pop
// cycle it derives gate rise, pulse rise times, gate fall, done and
// underrun by interval arithmetic, and compares the DUT every cycle.
module tb_flux_write_encoder;

    localparam int FIFO_DEPTH   = 16;
    localparam int CNT_WIDTH    = 16;
    localparam int PULSE_WIDTH  = 10;
    localparam int MIN_INTERVAL = 20;
    localparam int LW           = $clog2(FIFO_DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [CNT_WIDTH-1:0] s_data = '0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 index_in = 1'b0;
    logic                 wr_gate;
    logic                 wr_data;
    logic                 busy;
    logic                 done;
    logic                 underrun;
    logic [LW-1:0]        fifo_level;
    logic [31:0]          pulse_count;

    flux_write_encoder #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .CNT_WIDTH   (CNT_WIDTH),
        .PULSE_WIDTH (PULSE_WIDTH),
        .MIN_INTERVAL(MIN_INTERVAL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .start      (start),
        .abort      (abort),
        .index_in   (index_in),
        .wr_gate    (wr_gate),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun),
        .fifo_level (fifo_level),
        .pulse_count(pulse_count)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // ---------------- timeline model ----------------
    int m_S, m_gate_rise, m_fall, m_end, m_done_cyc;
    int m_rise[$];
    bit m_und;
    bit mon_en = 1'b0;

    function automatic int eff(input int n);
        return (n < MIN_INTERVAL) ? MIN_INTERVAL : n;
    endfunction

    // S: edge that samples start; A: edge at which the first word is popped
    function automatic void plan(input int words[$], input int S, input int A);
        int t;
        int i;
        bit ended;
        m_S = S;
        m_rise.delete();
        m_und = 1'b0;
        m_done_cyc = -1;
        if (words[0] == 0) begin
            m_gate_rise = -1;
            m_fall = -1;
            m_end = A;
            m_done_cyc = A;
            return;
        end
        m_gate_rise = A;
        t = A;
        i = 0;
        ended = 1'b0;
        while (1) begin
            if (i >= words.size()) begin m_und = 1'b1; break; end
            if (words[i] == 0) begin ended = 1'b1; break; end
            t += eff(words[i]);
            m_rise.push_back(t);
            i++;
        end
        m_fall = m_rise[m_rise.size()-1] + PULSE_WIDTH + 1;
        m_end = m_fall;
        if (ended) m_done_cyc = m_fall;
    endfunction

    function automatic bit exp_data(input int n);
        foreach (m_rise[k]) if (n >= m_rise[k] && n < m_rise[k] + PULSE_WIDTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_count(input int n);
        int c = 0;
        foreach (m_rise[k]) if (m_rise[k] <= n) c++;
        return c;
    endfunction

    // ---------------- compare + observer ----------------
    int obs_gate_rise, obs_fall, obs_done;
    int obs_rise[$];
    bit prev_gate = 1'b0, prev_data = 1'b0;

    always @(negedge clk) begin
        if (mon_en && cyc >= m_S) begin
            check("wr_gate", wr_gate, (m_gate_rise >= 0 && cyc >= m_gate_rise && cyc < m_fall));
            check("wr_data", wr_data, exp_data(cyc));
            check("busy", busy, (cyc >= m_S && cyc < m_end));
            check("done", done, (cyc == m_done_cyc));
            check("underrun", underrun, (m_und && cyc >= m_rise[m_rise.size()-1]));
            check("pulse_count", pulse_count, exp_count(cyc));
        end
        if (wr_gate && !prev_gate) obs_gate_rise = cyc;
        if (!wr_gate && prev_gate) obs_fall = cyc;
        if (wr_data && !prev_data) obs_rise.push_back(cyc);
        if (done) obs_done = cyc;
        prev_gate = wr_gate;
        prev_data = wr_data;
    end

    // ---------------- driver helpers ----------------
    task automatic push_words(input int words[$]);
        foreach (words[k]) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = CNT_WIDTH'(words[k]);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic clear_obs();
        obs_rise.delete();
        obs_gate_rise = -1;
        obs_fall = -1;
        obs_done = -1;
    endtask

    task automatic start_run(input int words[$]);
        clear_obs();
        @(negedge clk);
        start = 1'b1;
        plan(words, cyc + 1, cyc + 2);
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (cyc <= m_end + 1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("run_finished", (cyc > m_end + 1), 1);
        mon_en = 1'b0;
    endtask

    int w[$];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_gate", wr_gate, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_pulse_count", pulse_count, 0);
        rst = 1'b0;

        // 1: two pulses then end-of-stream
        w = {40, 60, 0};
        push_words(w);
        check("t1_level", fifo_level, 3);
        start_run(w);
        wait_idle(600);
        check("t1_npulses", obs_rise.size(), 2);
        if (obs_rise.size() >= 2) begin
            check("t1_rise0", obs_rise[0] - obs_gate_rise, 40);
            check("t1_rise1", obs_rise[1] - obs_gate_rise, 100);
        end
        check("t1_fall", obs_fall - obs_gate_rise, 111);
        check("t1_done_at_fall", obs_done, obs_fall);
        check("t1_pulse_count", pulse_count, 2);
        check("t1_underrun", underrun, 0);
        check("t1_level_end", fifo_level, 0);

        // 2: underrun after a single pulse
        w = {40};
        push_words(w);
        start_run(w);
        wait_idle(600);
        check("t2_npulses", obs_rise.size(), 1);
        if (obs_rise.size() >= 1) begin
            check("t2_rise0", obs_rise[0] - obs_gate_rise, 40);
            check("t2_fall", obs_fall - obs_rise[0], 11);
        end
        check("t2_no_done", obs_done, -1);
        check("t2_underrun", underrun, 1);
        check("t2_pulse_count", pulse_count, 1);

        // abort in IDLE: flush, same-cycle push dropped, underrun kept
        w = {50, 50, 50};
        push_words(w);
        check("ab_level_pre", fifo_level, 3);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 16'd77;
        abort   = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        abort   = 1'b0;
        check("ab_level", fifo_level, 0);
        check("ab_underrun", underrun, 1);
        check("ab_busy", busy, 0);

        // 3: clamp, then empty stream
        w = {5, 0};
        push_words(w);
        start_run(w);
        wait_idle(600);
        check("t3_npulses", obs_rise.size(), 1);
        if (obs_rise.size() >= 1) check("t3_clamp", obs_rise[0] - obs_gate_rise, 20);
        check("t3_underrun_cleared", underrun, 0);
        w = {0};
        push_words(w);
        start_run(w);
        wait_idle(100);
        check("t3_gate_never", obs_gate_rise, -1);
        check("t3_done_lat", obs_done - m_S, 1);

        // 4: FIFO full behaviour
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 15) check("t4_ready_15", s_ready, 1);
            if (i == 16) check("t4_level_16", fifo_level, 16);
            s_valid = 1'b1;
            s_data  = CNT_WIDTH'(100 + i);
        end
        @(negedge clk);
        s_valid = 1'b0;
        check("t4_level_full", fifo_level, 16);
        check("t4_ready_full", s_ready, 0);
        w.delete();
        for (int i = 0; i < 16; i++) w.push_back(100 + i);
        start_run(w);
        @(negedge clk);
        check("t4_level_pop", fifo_level, 15);
        check("t4_ready_pop", s_ready, 1);
        wait_idle(2500);
        check("t4_pulse_count", pulse_count, 16);
        check("t4_underrun", underrun, 1);

        // 5: abort mid-pulse, then reset mid-pulse
        for (int pass = 0; pass < 2; pass++) begin
            w.delete();
            for (int i = 0; i < 10; i++) w.push_back(30);
            push_words(w);
            start_run(w);
            repeat (32) @(negedge clk);
            check("t5_mid_pulse", wr_data, 1);
            mon_en = 1'b0;
            if (pass == 0) abort = 1'b1;
            else           rst = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            rst   = 1'b0;
            check("t5_wr_gate", wr_gate, 0);
            check("t5_wr_data", wr_data, 0);
            check("t5_level", fifo_level, 0);
            check("t5_busy", busy, 0);
            check("t5_underrun", underrun, 0);
            check("t5_done", done, 0);
            check("t5_pulse_count", pulse_count, (pass == 0) ? 1 : 0);
            repeat (5) @(negedge clk);
            check("t5_gate_stays", wr_gate, 0);
        end

        // 6: index synchronisation
        w = {40, 0};
        push_words(w);
        clear_obs();
`ifdef FLUX_WRITE_INDEX_SYNC_EN
        @(negedge clk);
        start = 1'b1;
        index_in = 1'b0;
        plan(w, cyc + 1, cyc + 52);
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < m_S + 50) @(negedge clk);
        index_in = 1'b1;
        wait_idle(600);
        index_in = 1'b0;
        check("t6_gate_delay", obs_gate_rise - m_S, 51);
`else
        index_in = 1'b1;
        start_run(w);
        wait_idle(600);
        index_in = 1'b0;
        check("t6_gate_delay", obs_gate_rise - m_S, 1);
`endif
        if (obs_rise.size() >= 1) check("t6_rise0", obs_rise[0] - obs_gate_rise, 40);
        check("t6_pulse_count", pulse_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
